gf2_limb_mult_seq: RTL and testbench

Multi-cycle GF(2)[x] polynomial multiplier. It splits two K·W-bit operands into K limbs of W bits each. It runs all K² limb-pair products through a single shared W-bit `gf2_schoolbook_mult` instance and XOR-accumulates each product at its shifted offset. The block is the area-saving core that Toom-K evaluation/interpolation stages call for full-width products, with valid/ready handshakes on both sides.

---
 rtl/gf2_limb_mult_seq_if.sv | 25 ++
 rtl/gf2_limb_mult_seq.sv | 152 +++++++++++++++
 tb/tb_gf2_limb_mult_seq.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/gf2_limb_mult_seq_if.sv
// Operand/result handshake bundle for gf2_limb_mult_seq; state is a debug view of the FSM.
interface gf2_limb_mult_seq_if #(
  parameter int W = 64,
  parameter int K = 4
);
  logic               in_valid;
  logic               in_ready;
  logic [0:K*W-1]     a;
  logic [0:K*W-1]     b;
  logic               out_valid;
  logic               out_ready;
  logic [0:2*K*W-1]   c;
  logic               busy;
  logic [1:0]         state;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, c, busy, state
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, c, busy, state
  );
endinterface

// File: rtl/gf2_limb_mult_seq.sv
// Sequential GF(2)[x] multiplier: K*K limb products through one shared W-bit schoolbook core.
// Optional macro GF2_LIMB_MUL_PIPE_EN registers the limb product and adds a DRAIN state.
module gf2_schoolbook_mult #(
  parameter int N = 64
) (
  input  logic [0:N-1]   x,
  input  logic [0:N-1]   y,
  output logic [0:2*N-1] p
);
  logic [0:2*N-1] y_ext;

  assign y_ext = {y, {N{1'b0}}};

  // Ascending vectors: >> moves a coefficient to a higher degree.
  always_comb begin
    p = '0;
    for (int i = 0; i < N; i++) begin
      if (x[i]) p = p ^ (y_ext >> i);
    end
  end
endmodule

module gf2_limb_mult_seq #(
  parameter int W = 64,
  parameter int K = 4
) (
  input logic               clk,
  input logic               rst,
  gf2_limb_mult_seq_if.slave bus
);
  localparam int CW = (K > 1) ? $clog2(K) : 1;
  localparam int AW = 2 * K * W;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // valid never waits on ready, and c is held stable while out_valid is high.
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

  state_t           state, state_nx;
  logic [CW-1:0]    i_q, j_q;
  logic [0:K*W-1]   a_q, b_q;
  logic [0:AW-1]    acc;
  logic [0:W-1]     limb_a, limb_b;
  logic [0:2*W-1]   pp;
  logic [CW:0]      off;
  logic             last;
  logic [0:2*W-1]   add_pp;
  logic [CW:0]      add_off;
  logic             add_en;
  logic [0:AW-1]    contrib;

  assign limb_a = a_q[i_q*W +: W];
  assign limb_b = b_q[j_q*W +: W];
  assign off    = {1'b0, i_q} + {1'b0, j_q};
  assign last   = (i_q == CW'(K-1)) && (j_q == CW'(K-1));

  gf2_schoolbook_mult #(.N(W)) u_mult (
    .x (limb_a),
    .y (limb_b),
    .p (pp)
  );

`ifdef GF2_LIMB_MUL_PIPE_EN
  logic [0:2*W-1] pp_q;
  logic [CW:0]    off_q;
  logic           pv_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pp_q  <= '0;
      off_q <= '0;
      pv_q  <= 1'b0;
    end else begin
      pp_q  <= pp;
      off_q <= off;
      pv_q  <= (state == RUN);
    end
  end

  assign add_pp  = pp_q;
  assign add_off = off_q;
  assign add_en  = pv_q && ((state == RUN) || (state == DRAIN));
`else
  assign add_pp  = pp;
  assign add_off = off;
  assign add_en  = (state == RUN);
`endif

  assign contrib = {add_pp, {(AW-2*W){1'b0}}} >> (add_off * W);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (bus.in_valid) state_nx = RUN;
      RUN: begin
        if (last) begin
`ifdef GF2_LIMB_MUL_PIPE_EN
          state_nx = DRAIN;
`else
          state_nx = DONE;
`endif
        end
      end
`ifdef GF2_LIMB_MUL_PIPE_EN
      DRAIN: state_nx = DONE;
`endif
      DONE: if (bus.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.busy      = (state != IDLE);
    bus.out_valid = (state == DONE);
    bus.state     = state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
      acc <= '0;
      i_q <= '0;
      j_q <= '0;
    end else begin
      if (state == IDLE && bus.in_valid) begin
        a_q <= bus.a;
        b_q <= bus.b;
        acc <= '0;
        i_q <= '0;
        j_q <= '0;
      end else begin
        if (add_en) acc <= acc ^ contrib;
        if (state == RUN) begin
          if (j_q == CW'(K-1)) begin
            j_q <= '0;
            i_q <= last ? '0 : i_q + CW'(1);
          end else begin
            j_q <= j_q + CW'(1);
          end
        end
      end
    end
  end

  assign bus.c = acc;
endmodule

// File: tb/tb_gf2_limb_mult_seq.sv
// Directed-vector and model-checked bench for gf2_limb_mult_seq (W=64, K=4).
module tb_gf2_limb_mult_seq;
  localparam int W = 64;
  localparam int K = 4;
  localparam int OW = K * W;
  localparam int CWID = 2 * K * W;
`ifdef GF2_LIMB_MUL_PIPE_EN
  localparam int EXP_LAT = K * K + 2;
`else
  localparam int EXP_LAT = K * K + 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  gf2_limb_mult_seq_if #(.W(W), .K(K)) bus ();

  gf2_limb_mult_seq #(.W(W), .K(K)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [0:OW-1]   a;
    logic [0:OW-1]   b;
    logic [0:CWID-1] c;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [0:CWID-1] got, input logic [0:CWID-1] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic check1(input string name, input logic got, input logic exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%b exp=%b", name, got, exp);
    end
  endtask

  function automatic logic [0:CWID-1] clmul(input logic [0:OW-1] x, input logic [0:OW-1] y);
    logic [0:CWID-1] r;
    r = '0;
    for (int i = 0; i < OW; i++)
      if (x[i])
        for (int j = 0; j < OW; j++)
          r[i+j] = r[i+j] ^ y[j];
    return r;
  endfunction

  function automatic logic [0:OW-1] rnd256();
    logic [0:OW-1] r;
    for (int k = 0; k < OW / 32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT back in IDLE.
  task automatic run_op(input logic [0:OW-1] ta, input logic [0:OW-1] tb_v,
                        output logic [0:CWID-1] got, output int lat);
    int n;
    n = 0;
    bus.a = ta;
    bus.b = tb_v;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.a = rnd256();
    bus.b = rnd256();
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    got = bus.c;
    if (!bus.out_valid) begin
      fails++;
      tests++;
      $display("FAIL run_op_timeout got=no_out_valid exp=out_valid");
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    logic [0:OW-1]   ta, tbv, na, nb, r_fix, ones;
    logic [0:CWID-1] got, exp, held;
    int              lat, n;
    vec_t            v;

    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.a = '0;
    bus.b = '0;

    r_fix = 256'h0123456789abcdef_fedcba9876543210_a5a5a5a55a5a5a5a_deadbeefcafef00d;
    ones  = '1;

    v.a = '0; v.b = r_fix; v.a[0] = 1'b1;
    v.c = '0; v.c[0:OW-1] = r_fix;                             vecs[0] = v;
    v.a = '0; v.b = '0; v.a[255] = 1'b1; v.b[255] = 1'b1;
    v.c = '0; v.c[510] = 1'b1;                                 vecs[1] = v;
    v.a = '0; v.b = '0; v.a[1] = 1'b1; v.b[63] = 1'b1;
    v.c = '0; v.c[64] = 1'b1;                                  vecs[2] = v;
    v.a = '0; v.a[0] = 1'b1; v.a[64] = 1'b1; v.b = v.a;
    v.c = '0; v.c[0] = 1'b1; v.c[128] = 1'b1;                  vecs[3] = v;
    v.a = '0; v.a[0] = 1'b1; v.a[1] = 1'b1; v.b = v.a;
    v.c = '0; v.c[0] = 1'b1; v.c[2] = 1'b1;                    vecs[4] = v;
    v.a = ones; v.b = '0; v.b[0] = 1'b1;
    v.c = '0; v.c[0:OW-1] = ones;                              vecs[5] = v;
    v.a = '0; v.a[0:63] = '1; v.b = '0; v.b[0] = 1'b1; v.b[1] = 1'b1;
    v.c = '0; v.c[0] = 1'b1; v.c[64] = 1'b1;                   vecs[6] = v;
    v.a = '0; v.b = ones; v.c = '0;                            vecs[7] = v;
    v.a = '0; v.b = '0; v.a[200] = 1'b1; v.b[100] = 1'b1;
    v.c = '0; v.c[300] = 1'b1;                                 vecs[8] = v;

    repeat (3) @(negedge clk);
    check1("reset_in_ready", bus.in_ready, 1'b1);
    check1("reset_out_valid", bus.out_valid, 1'b0);
    check1("reset_busy", bus.busy, 1'b0);
    check("reset_c", bus.c, '0);
    rst = 1'b0;
    @(negedge clk);

    for (int k = 0; k < 9; k++) begin
      run_op(vecs[k].a, vecs[k].b, got, lat);
      check($sformatf("vec%0d_c", k), got, vecs[k].c);
      check($sformatf("vec%0d_lat", k), CWID'(lat), CWID'(EXP_LAT));
    end

    for (int k = 0; k < 200; k++) begin
      ta = rnd256();
      tbv = rnd256();
      exp = clmul(ta, tbv);
      run_op(ta, tbv, got, lat);
      check($sformatf("rand%0d_c", k), got, exp);
      check1($sformatf("rand%0d_top", k), got[CWID-1], 1'b0);
      if (k < 50) check($sformatf("rand%0d_lat", k), CWID'(lat), CWID'(EXP_LAT));
    end

    // Backpressure with stray input traffic while DONE is held.
    ta = rnd256(); tbv = rnd256(); exp = clmul(ta, tbv);
    na = rnd256(); nb = rnd256();
    bus.a = ta; bus.b = tbv; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check1("bp_busy_run", bus.busy, 1'b1);
    check1("bp_in_ready_run", bus.in_ready, 1'b0);
    n = 0;
    while (!bus.out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    held = bus.c;
    check("bp_first_c", held, exp);
    for (int k = 0; k < 10; k++) begin
      bus.in_valid = k[0];
      bus.a = (k[0]) ? na : ~na;
      bus.b = nb;
      @(negedge clk);
      check($sformatf("bp_hold_c%0d", k), bus.c, held);
      check1($sformatf("bp_hold_ov%0d", k), bus.out_valid, 1'b1);
      check1($sformatf("bp_hold_ir%0d", k), bus.in_ready, 1'b0);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check1("bp_release_ir", bus.in_ready, 1'b1);
    check1("bp_release_ov", bus.out_valid, 1'b0);
    run_op(na, nb, got, lat);
    check("bp_next_c", got, clmul(na, nb));

    // Reset in the fifth RUN cycle discards the partial product.
    bus.a = rnd256(); bus.b = rnd256(); bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check1("rst_mid_busy_before", bus.busy, 1'b1);
    check1("rst_mid_ov_before", bus.out_valid, 1'b0);
    bus.out_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check1("rst_mid_in_ready", bus.in_ready, 1'b1);
    check1("rst_mid_busy", bus.busy, 1'b0);
    check1("rst_mid_out_valid", bus.out_valid, 1'b0);
    check("rst_mid_c", bus.c, '0);
    run_op(ones, ones, got, lat);
    check("rst_mid_ones_c", got, clmul(ones, ones));
    check("rst_mid_ones_lat", CWID'(lat), CWID'(EXP_LAT));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
